// File: rtl/accumulator_seq_ctrl_if.sv
// Handshake and control bundle between the accumulator sequencer,
// its job controller, the systolic array and the accumulator bank.
interface accumulator_seq_ctrl_if #(
  parameter int ADDR_WIDTH = 3
);
  logic                  start;
  logic                  cfg_test_mode;
  logic [ADDR_WIDTH:0]   cfg_rows;
  logic                  psum_valid;
  logic                  psum_ready;
  logic                  acc_wr_en;
  logic [ADDR_WIDTH-1:0] acc_wr_addr;
  logic                  acc_test_mode;
  logic [ADDR_WIDTH-1:0] acc_rd_addr;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic                  busy;
  logic                  done;

  modport master (
    output start,
    output cfg_test_mode,
    output cfg_rows,
    output psum_valid,
    output out_ready,
    input  psum_ready,
    input  acc_wr_en,
    input  acc_wr_addr,
    input  acc_test_mode,
    input  acc_rd_addr,
    input  out_valid,
    input  out_last,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  cfg_test_mode,
    input  cfg_rows,
    input  psum_valid,
    input  out_ready,
    output psum_ready,
    output acc_wr_en,
    output acc_wr_addr,
    output acc_test_mode,
    output acc_rd_addr,
    output out_valid,
    output out_last,
    output busy,
    output done
  );
endinterface

// File: rtl/accumulator_seq_ctrl.sv
// Write/drain/read sequencer for the column-skewed accumulator bank.
// Ports: clk, rst_n (async low), bus (slave side of the job interface).
module accumulator_seq_ctrl #(
  parameter int SYSTOLIC_SIZE  = 8,
  parameter int PATTERN_NUMBER = 1,
  parameter int ADDR_WIDTH     =
    $clog2(PATTERN_NUMBER * SYSTOLIC_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  accumulator_seq_ctrl_if.slave bus
);
  localparam int DEPTH = PATTERN_NUMBER * SYSTOLIC_SIZE;
  localparam int DW    = $clog2(SYSTOLIC_SIZE) + 1;

  localparam logic [ADDR_WIDTH:0] DEPTH_C =
    (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_C =
    (ADDR_WIDTH+1)'(1);
  localparam logic [DW-1:0] DRAIN_LAST =
    DW'((SYSTOLIC_SIZE > 1) ? SYSTOLIC_SIZE - 2 : 0);
  localparam bit HAS_DRAIN = (SYSTOLIC_SIZE > 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WRITE = 3'd1;
  localparam logic [2:0] DRAIN = 3'd2;
  localparam logic [2:0] READ  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]            state;
  logic                  mode_r;
  logic [ADDR_WIDTH:0]   rows_r;
  logic [ADDR_WIDTH-1:0] wr_cnt;
  logic [ADDR_WIDTH-1:0] rd_cnt;
  logic [DW-1:0]         drain_cnt;

  logic [ADDR_WIDTH:0]   rows_in;
  logic [ADDR_WIDTH:0]   last_idx;
  logic                  wr_last;
  logic                  rd_last;

  assign rows_in  = (bus.cfg_rows > DEPTH_C) ?
                    DEPTH_C : bus.cfg_rows;
  assign last_idx = rows_r - ONE_C;
  assign wr_last  = ({1'b0, wr_cnt} == last_idx);
  assign rd_last  = ({1'b0, rd_cnt} == last_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode_r    <= 1'b0;
      rows_r    <= '0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      drain_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            mode_r    <= bus.cfg_test_mode;
            rows_r    <= rows_in;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            drain_cnt <= '0;
            state     <= (rows_in == '0) ? DONE : WRITE;
          end
        end
        WRITE: begin
          if (bus.psum_valid) begin
            if (wr_last) begin
              // test mode bypasses the column skew
              state <= (mode_r || !HAS_DRAIN) ?
                       READ : DRAIN;
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state <= READ;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        READ: begin
          if (bus.out_ready) begin
            if (rd_last) begin
              state <= DONE;
            end else begin
              rd_cnt <= rd_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          // addresses park at 0 between jobs
          state  <= IDLE;
          wr_cnt <= '0;
          rd_cnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.psum_ready    = (state == WRITE);
  assign bus.acc_wr_en     = (state == WRITE) &&
                             bus.psum_valid;
  assign bus.acc_wr_addr   = wr_cnt;
  assign bus.acc_test_mode = (state != IDLE) && mode_r;
  assign bus.acc_rd_addr   = rd_cnt;
  assign bus.out_valid     = (state == READ);
  assign bus.out_last      = (state == READ) && rd_last;
  assign bus.busy          = (state != IDLE);
  assign bus.done          = (state == DONE);
endmodule

// File: tb/tb_accumulator_seq_ctrl.sv
// Scoreboard bench for accumulator_seq_ctrl.
// Queues expected write/read addresses per job.
module tb_accumulator_seq_ctrl;
  localparam int S  = 8;
  localparam int P  = 1;
  localparam int AW = 3;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          last;
  } rd_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  accumulator_seq_ctrl_if #(.ADDR_WIDTH(AW)) bus();

  accumulator_seq_ctrl #(
    .SYSTOLIC_SIZE (S),
    .PATTERN_NUMBER(P),
    .ADDR_WIDTH    (AW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int n_vec     = 0;
  int n_err     = 0;
  int done_cnt  = 0;
  int drain_cyc = 0;
  int stall_cyc = 0;
  logic exp_mode = 1'b0;

  logic [AW-1:0] wr_q[$];
  rd_t           rd_q[$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({bus.psum_ready, bus.acc_wr_en,
                bus.acc_wr_addr, bus.acc_test_mode,
                bus.acc_rd_addr, bus.out_valid,
                bus.out_last, bus.busy, bus.done});
  endfunction

  task automatic load_q(input int eff);
    rd_t e;
    wr_q.delete();
    rd_q.delete();
    for (int i = 0; i < eff; i++) begin
      wr_q.push_back(AW'(i));
      e.addr = AW'(i);
      e.last = (i == eff - 1);
      rd_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.psum_ready)
        chk("wr_en", 32'(bus.acc_wr_en),
            32'(bus.psum_valid));
      else if (bus.acc_wr_en)
        chk("wr_en_idle", 32'(1), 32'(0));
      if (bus.acc_wr_en) begin
        if (wr_q.size() == 0)
          chk("wr_extra", 32'(1), 32'(0));
        else
          chk("wr_addr", 32'(bus.acc_wr_addr),
              32'(wr_q.pop_front()));
      end
      if (bus.out_valid) begin
        if (rd_q.size() == 0) begin
          chk("rd_extra", 32'(1), 32'(0));
        end else begin
          chk("rd_addr", 32'(bus.acc_rd_addr),
              32'(rd_q[0].addr));
          chk("rd_last", 32'(bus.out_last),
              32'(rd_q[0].last));
          if (bus.out_ready)
            void'(rd_q.pop_front());
          else
            stall_cyc++;
        end
      end else if (bus.out_last) begin
        chk("last_idle", 32'(1), 32'(0));
      end
      chk("test_mode", 32'(bus.acc_test_mode),
          32'(bus.busy ? exp_mode : 1'b0));
      if (!bus.busy)
        chk("idle_addr",
            32'({bus.acc_wr_addr, bus.acc_rd_addr}),
            32'(0));
      if (bus.done) done_cnt++;
      if (bus.busy && !bus.psum_ready &&
          !bus.out_valid && !bus.done)
        drain_cyc++;
    end
  end

  task automatic run_job(input logic m,
                         input int   rows,
                         input bit   toggle,
                         input bit   stall,
                         input bit   restart,
                         input int   exp_span);
    int eff;
    int cyc;
    int left;
    int d0;
    bit got;
    eff  = (rows > S * P) ? S * P : rows;
    cyc  = 0;
    left = 3;
    got  = 1'b0;
    load_q(eff);
    drain_cyc = 0;
    stall_cyc = 0;
    d0 = done_cnt;
    exp_mode = m;
    bus.start         = 1'b1;
    bus.cfg_test_mode = m;
    bus.cfg_rows      = (AW+1)'(rows);
    bus.psum_valid    = 1'b1;
    bus.out_ready     = 1'b1;
    while (!got && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      bus.start = restart && (cyc == 2);
      if (restart && cyc == 2) begin
        bus.cfg_test_mode = ~m;
        bus.cfg_rows      = (AW+1)'(3);
      end
      if (toggle) bus.psum_valid = ~bus.psum_valid;
      if (stall && bus.out_valid &&
          bus.acc_rd_addr == 2 && left > 0) begin
        bus.out_ready = 1'b0;
        left--;
      end else begin
        bus.out_ready = 1'b1;
      end
      got = bus.done;
    end
    bus.start = 1'b0;
    chk("timeout", 32'(got), 32'(1));
    chk("span", 32'(cyc + 1), 32'(exp_span));
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("done_pulses", 32'(done_cnt - d0), 32'(1));
    chk("busy_end", 32'(bus.busy), 32'(0));
    chk("wr_left", 32'(wr_q.size()), 32'(0));
    chk("rd_left", 32'(rd_q.size()), 32'(0));
    chk("drain", 32'(drain_cyc),
        32'((m || eff == 0) ? 0 : S - 1));
    if (stall)
      chk("stall", 32'(stall_cyc), 32'(3));
    bus.psum_valid = 1'b0;
  endtask

  initial begin
    int cyc;
    bus.start         = 1'b0;
    bus.cfg_test_mode = 1'b0;
    bus.cfg_rows      = '0;
    bus.psum_valid    = 1'b0;
    bus.out_ready     = 1'b0;
    #12;
    chk("reset_outs", outs(), 32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_job(1'b0, 8,  0, 0, 0, 25);
    run_job(1'b1, 4,  0, 0, 0, 10);
    run_job(1'b0, 8,  1, 1, 0, 36);
    run_job(1'b0, 0,  0, 0, 0, 2);
    run_job(1'b1, 15, 0, 0, 0, 18);
    run_job(1'b0, 8,  0, 0, 1, 25);

    load_q(8);
    exp_mode          = 1'b0;
    bus.start         = 1'b1;
    bus.cfg_test_mode = 1'b0;
    bus.cfg_rows      = (AW+1)'(8);
    bus.psum_valid    = 1'b1;
    bus.out_ready     = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      bus.start = 1'b0;
    end while (!(bus.out_valid &&
                 bus.acc_rd_addr == 5) && cyc < 100);
    chk("reach_rd5", 32'(bus.acc_rd_addr), 32'(5));
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_mid", outs(), 32'(0));
    wr_q.delete();
    rd_q.delete();
    @(posedge clk);
    #1;
    chk("reset_hold", outs(), 32'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_job(1'b0, 8, 0, 0, 0, 25);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
